// File: rtl/dbf_sum_n.sv
// dbf_sum_n: multi-channel complex beamforming sum with double-buffered weights.
// Each channel's I/Q is multiplied by its own complex weight. The weighted
// channels go through a pipelined adder tree, then a rounding right shift
// and a saturation stage. Latency is 4 + log2(CH) cycles.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   din_i/din_q        CH packed signed samples; channel k at [k*DW +: DW]
//   din_valid          input strobe, one sample per cycle
//   w_wr_en/ch/re/im   write one shadow weight
//   w_commit           copy the shadow bank into the active bank
//   dout_i/dout_q      beam output; holds its value between strobes
//   dout_valid         output strobe
//   sat_flag           I or Q was clipped on this output sample
module dbf_sum_n #(
    parameter int CH    = 4,
    parameter int DW    = 16,
    parameter int WW    = 16,
    parameter int OW    = 32,
    parameter int SHIFT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CH*DW-1:0]      din_i,
    input  logic [CH*DW-1:0]      din_q,
    input  logic                  din_valid,
    input  logic                  w_wr_en,
    input  logic [$clog2(CH)-1:0] w_wr_ch,
    input  logic [WW-1:0]         w_wr_re,
    input  logic [WW-1:0]         w_wr_im,
    input  logic                  w_commit,
    output logic [OW-1:0]         dout_i,
    output logic [OW-1:0]         dout_q,
    output logic                  dout_valid,
    output logic                  sat_flag
);

    localparam int LG  = $clog2(CH);
    localparam int CW  = LG;
    localparam int PW  = DW + WW;
    localparam int RW  = PW + 1;
    localparam int TW  = RW + LG;
    localparam int L   = 4 + LG;
    localparam int EW  = (TW + 1 > OW + 1) ? TW + 1 : OW + 1;
    localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [EW-1:0] RND  =
        (SHIFT > 0) ? (EW'(1) <<< RSH) : EW'(0);
    localparam logic signed [EW-1:0] MAXV =
        (EW'(1) <<< (OW - 1)) - EW'(1);
    localparam logic signed [EW-1:0] MINV =
        -(EW'(1) <<< (OW - 1));

    // Weight banks
    logic signed [WW-1:0] sh_re_q [CH];
    logic signed [WW-1:0] sh_im_q [CH];
    logic signed [WW-1:0] ac_re_q [CH];
    logic signed [WW-1:0] ac_im_q [CH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < CH; k++) begin
                sh_re_q[k] <= '0;
                sh_im_q[k] <= '0;
                ac_re_q[k] <= '0;
                ac_im_q[k] <= '0;
            end
        end else begin
            if (w_wr_en) begin
                sh_re_q[w_wr_ch] <= w_wr_re;
                sh_im_q[w_wr_ch] <= w_wr_im;
            end
            // A write in the commit cycle is forwarded into the active bank.
            if (w_commit) begin
                for (int k = 0; k < CH; k++) begin
                    if (w_wr_en && w_wr_ch == CW'(k)) begin
                        ac_re_q[k] <= w_wr_re;
                        ac_im_q[k] <= w_wr_im;
                    end else begin
                        ac_re_q[k] <= sh_re_q[k];
                        ac_im_q[k] <= sh_im_q[k];
                    end
                end
            end
        end
    end

    // Stage valids: [0]=S1, [1]=S2, [2]=S3, tree levels, [L-1]=output
    logic [L-1:0] vld_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[L-2:0], din_valid};
        end
    end

    assign dout_valid = vld_q[L-1];

    // S1: inputs plus a snapshot of the active weights
    logic signed [DW-1:0] ai_q [CH];
    logic signed [DW-1:0] aq_q [CH];
    logic signed [WW-1:0] wr_q [CH];
    logic signed [WW-1:0] wi_q [CH];

    always_ff @(posedge clk) begin
        if (din_valid) begin
            for (int k = 0; k < CH; k++) begin
                ai_q[k] <= din_i[k*DW +: DW];
                aq_q[k] <= din_q[k*DW +: DW];
                wr_q[k] <= ac_re_q[k];
                wi_q[k] <= ac_im_q[k];
            end
        end
    end

    // S2: partial products
    logic signed [PW-1:0] prr_q [CH];
    logic signed [PW-1:0] pii_q [CH];
    logic signed [PW-1:0] pri_q [CH];
    logic signed [PW-1:0] pir_q [CH];

    always_ff @(posedge clk) begin
        if (vld_q[0]) begin
            for (int k = 0; k < CH; k++) begin
                prr_q[k] <= PW'(ai_q[k]) * PW'(wr_q[k]);
                pii_q[k] <= PW'(aq_q[k]) * PW'(wi_q[k]);
                pri_q[k] <= PW'(ai_q[k]) * PW'(wi_q[k]);
                pir_q[k] <= PW'(aq_q[k]) * PW'(wr_q[k]);
            end
        end
    end

    // S3: complex product per channel
    logic signed [RW-1:0] re_q [CH];
    logic signed [RW-1:0] im_q [CH];

    always_ff @(posedge clk) begin
        if (vld_q[1]) begin
            for (int k = 0; k < CH; k++) begin
                re_q[k] <= RW'(prr_q[k]) - RW'(pii_q[k]);
                im_q[k] <= RW'(pri_q[k]) + RW'(pir_q[k]);
            end
        end
    end

    // Adder tree, full width at every level so the sum stays exact
    for (genvar l = 0; l < LG; l++) begin : g_lvl
        localparam int N = CH >> (l + 1);
        logic signed [TW-1:0] ini  [2*N];
        logic signed [TW-1:0] inq  [2*N];
        logic signed [TW-1:0] si_q [N];
        logic signed [TW-1:0] sq_q [N];

        if (l == 0) begin : g_leaf
            always_comb begin
                for (int n = 0; n < 2 * N; n++) begin
                    ini[n] = TW'(re_q[n]);
                    inq[n] = TW'(im_q[n]);
                end
            end
        end else begin : g_node
            always_comb begin
                for (int n = 0; n < 2 * N; n++) begin
                    ini[n] = g_lvl[l-1].si_q[n];
                    inq[n] = g_lvl[l-1].sq_q[n];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (vld_q[2+l]) begin
                for (int n = 0; n < N; n++) begin
                    si_q[n] <= ini[2*n] + ini[2*n+1];
                    sq_q[n] <= inq[2*n] + inq[2*n+1];
                end
            end
        end
    end

    logic signed [TW-1:0] root_i;
    logic signed [TW-1:0] root_q;

    assign root_i = g_lvl[LG-1].si_q[0];
    assign root_q = g_lvl[LG-1].sq_q[0];

    // Round half up, then arithmetic shift; one extra bit absorbs the carry
    function automatic logic signed [EW-1:0] rnd_shift(
        input logic signed [TW-1:0] x
    );
        return (EW'(x) + RND) >>> SHIFT;
    endfunction

    logic signed [EW-1:0] ei_d;
    logic signed [EW-1:0] eq_d;
    logic [OW-1:0] dout_i_d;
    logic [OW-1:0] dout_q_d;
    logic hi_i, lo_i, hi_q, lo_q;
    logic sat_d;

    always_comb begin
        ei_d = rnd_shift(root_i);
        eq_d = rnd_shift(root_q);
        hi_i = ei_d > MAXV;
        lo_i = ei_d < MINV;
        hi_q = eq_d > MAXV;
        lo_q = eq_d < MINV;
        dout_i_d = ei_d[OW-1:0];
        dout_q_d = eq_d[OW-1:0];
        if (hi_i) dout_i_d = MAXV[OW-1:0];
        if (lo_i) dout_i_d = MINV[OW-1:0];
        if (hi_q) dout_q_d = MAXV[OW-1:0];
        if (lo_q) dout_q_d = MINV[OW-1:0];
        sat_d = hi_i | lo_i | hi_q | lo_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_i   <= '0;
            dout_q   <= '0;
            sat_flag <= 1'b0;
        end else if (vld_q[L-2]) begin
            dout_i   <= dout_i_d;
            dout_q   <= dout_q_d;
            sat_flag <= sat_d;
        end
    end

endmodule

// File: tb/tb_dbf_sum_n.sv
// tb_dbf_sum_n: directed test of dbf_sum_n with a cycle-by-cycle
// behavioural model and hand-computed spot checks.
module tb_dbf_sum_n;

    localparam int CH    = 4;
    localparam int DW    = 16;
    localparam int WW    = 16;
    localparam int OW    = 32;
    localparam int SHIFT = 1;
    localparam int L     = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic [CH*DW-1:0] din_i;
    logic [CH*DW-1:0] din_q;
    logic             din_valid;
    logic             w_wr_en;
    logic [1:0]       w_wr_ch;
    logic [WW-1:0]    w_wr_re;
    logic [WW-1:0]    w_wr_im;
    logic             w_commit;
    logic [OW-1:0]    dout_i;
    logic [OW-1:0]    dout_q;
    logic             dout_valid;
    logic             sat_flag;

    dbf_sum_n #(
        .CH(CH), .DW(DW), .WW(WW), .OW(OW), .SHIFT(SHIFT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din_i     (din_i),
        .din_q     (din_q),
        .din_valid (din_valid),
        .w_wr_en   (w_wr_en),
        .w_wr_ch   (w_wr_ch),
        .w_wr_re   (w_wr_re),
        .w_wr_im   (w_wr_im),
        .w_commit  (w_commit),
        .dout_i    (dout_i),
        .dout_q    (dout_q),
        .dout_valid(dout_valid),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input longint act,
                       input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int     due;
        longint vi;
        longint vq;
        bit     vs;
    } exp_t;

    exp_t   expq[$];
    longint sh_re[CH], sh_im[CH], ac_re[CH], ac_im[CH];
    int     cyc    = 0;
    longint last_i = 0;
    longint last_q = 0;
    bit     last_s = 0;
    bit     chk_en = 0;
    bit     m_ev;

    localparam longint MAXO = (longint'(1) << (OW - 1)) - 1;
    localparam longint MINO = -(longint'(1) << (OW - 1));

    function automatic exp_t beam(input int due);
        exp_t   e;
        longint si = 0;
        longint sq = 0;
        longint ar, ai, rnd;
        for (int k = 0; k < CH; k++) begin
            ar = longint'($signed(din_i[k*DW +: DW]));
            ai = longint'($signed(din_q[k*DW +: DW]));
            si += ar * ac_re[k] - ai * ac_im[k];
            sq += ar * ac_im[k] + ai * ac_re[k];
        end
        rnd = (SHIFT > 0) ? (longint'(1) << (SHIFT - 1)) : 0;
        si = (si + rnd) >>> SHIFT;
        sq = (sq + rnd) >>> SHIFT;
        e.vs = 0;
        if (si > MAXO) begin si = MAXO; e.vs = 1; end
        if (si < MINO) begin si = MINO; e.vs = 1; end
        if (sq > MAXO) begin sq = MAXO; e.vs = 1; end
        if (sq < MINO) begin sq = MINO; e.vs = 1; end
        e.due = due;
        e.vi  = si;
        e.vq  = sq;
        return e;
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            expq.delete();
            for (int k = 0; k < CH; k++) begin
                sh_re[k] = 0; sh_im[k] = 0;
                ac_re[k] = 0; ac_im[k] = 0;
            end
            last_i = 0; last_q = 0; last_s = 0;
        end else begin
            if (din_valid) expq.push_back(beam(cyc + L - 1));
            if (w_commit) begin
                for (int k = 0; k < CH; k++) begin
                    if (w_wr_en && w_wr_ch == k) begin
                        ac_re[k] = longint'($signed(w_wr_re));
                        ac_im[k] = longint'($signed(w_wr_im));
                    end else begin
                        ac_re[k] = sh_re[k];
                        ac_im[k] = sh_im[k];
                    end
                end
            end
            if (w_wr_en) begin
                sh_re[w_wr_ch] = longint'($signed(w_wr_re));
                sh_im[w_wr_ch] = longint'($signed(w_wr_im));
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            m_ev = 0;
            if (expq.size() > 0 && expq[0].due == cyc) begin
                m_ev   = 1;
                last_i = expq[0].vi;
                last_q = expq[0].vq;
                last_s = expq[0].vs;
                void'(expq.pop_front());
            end
            chk("model dout_valid", dout_valid, m_ev);
            chk("model dout_i", $signed(dout_i), last_i);
            chk("model dout_q", $signed(dout_q), last_q);
            chk("model sat_flag", sat_flag, last_s);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_ch(input int k, input int vi, input int vq);
        din_i[k*DW +: DW] = 16'(vi);
        din_q[k*DW +: DW] = 16'(vq);
    endtask

    task automatic set_all(input int vi, input int vq);
        for (int k = 0; k < CH; k++) set_ch(k, vi, vq);
    endtask

    task automatic wr_w(input int ch, input int re, input int im,
                        input bit c);
        w_wr_en  = 1;
        w_wr_ch  = 2'(ch);
        w_wr_re  = 16'(re);
        w_wr_im  = 16'(im);
        w_commit = c;
        @(negedge clk);
        w_wr_en  = 0;
        w_commit = 0;
    endtask

    task automatic commit();
        w_commit = 1;
        @(negedge clk);
        w_commit = 0;
    endtask

    task automatic pulse();
        din_valid = 1;
        @(negedge clk);
        din_valid = 0;
    endtask

    // Waits (bounded) for the next strobe after a single-sample pulse.
    task automatic expect_out(input string name, input longint ei,
                              input longint eq, input bit es);
        int got = 0;
        int n;
        for (n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (dout_valid) begin
                got = 1;
                break;
            end
        end
        chk({name, " latency"}, got ? n + 1 : 0, L);
        if (got) begin
            chk({name, " dout_i"}, $signed(dout_i), ei);
            chk({name, " dout_q"}, $signed(dout_q), eq);
            chk({name, " sat_flag"}, sat_flag, es);
        end
    endtask

    int           s_got;
    int           s_first;
    int           s_last;
    longint       s_v[8];
    logic [6:0]   pat;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1; din_i = '0; din_q = '0; din_valid = 0;
        w_wr_en = 0; w_wr_ch = '0; w_wr_re = '0; w_wr_im = '0;
        w_commit = 0;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1;
        chk("reset dout_valid", dout_valid, 0);
        chk("reset dout_i", $signed(dout_i), 0);
        chk("reset dout_q", $signed(dout_q), 0);
        chk("reset sat_flag", sat_flag, 0);
        rst = 0;

        // 1: unit-ish gain
        for (int k = 0; k < CH; k++) wr_w(k, 16384, 0, 0);
        commit();
        set_all(1000, 0);
        pulse();
        expect_out("t1", 32768000, 0, 0);

        // 2: 90 degree rotation on channel 0
        wr_w(0, 0, 16384, 0);
        for (int k = 1; k < CH; k++) wr_w(k, 0, 0, 0);
        commit();
        set_all(0, 0);
        set_ch(0, 1000, 0);
        pulse();
        expect_out("t2", 0, 8192000, 0);

        // 3: uncommitted write has no effect, forwarded commit, rounding
        wr_w(0, 5, 0, 0);
        pulse();
        expect_out("t3 nocommit", 0, 8192000, 0);
        wr_w(0, 1, 0, 1);
        set_ch(0, 3, 0);
        pulse();
        expect_out("t3 round pos", 2, 0, 0);
        set_ch(0, -3, 0);
        pulse();
        expect_out("t3 round neg", -1, 0, 0);

        // 4: saturation
        for (int k = 0; k < CH; k++) wr_w(k, -32768, 32767, 0);
        commit();
        set_all(-32768, -32768);
        pulse();
        expect_out("t4", 2147483647, 65536, 1);

        // 5: commit in the middle of a continuous stream
        for (int k = 0; k < CH; k++) wr_w(k, 16384, 0, 0);
        commit();
        for (int k = 0; k < CH; k++) wr_w(k, 8192, 0, 0);
        set_all(1000, 0);
        s_got = 0; s_first = -1; s_last = -1;
        for (int n = 0; n < 20; n++) begin
            din_valid = (n < 8);
            w_commit  = (n == 3);
            @(negedge clk);
            if (dout_valid) begin
                if (s_got < 8) s_v[s_got] = $signed(dout_i);
                if (s_first < 0) s_first = n;
                s_last = n;
                s_got++;
            end
        end
        din_valid = 0;
        w_commit  = 0;
        chk("t5 count", s_got, 8);
        chk("t5 no gap", s_last - s_first, 7);
        chk("t5 before commit", s_v[2], 32768000);
        chk("t5 commit sample", s_v[3], 32768000);
        chk("t5 after commit", s_v[4], 16384000);
        chk("t5 last", s_v[7], 16384000);

        // 6: reset with samples in flight
        set_all(500, 0);
        for (int n = 0; n < 3; n++) begin
            din_valid = 1;
            @(negedge clk);
        end
        din_valid = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk("t6 flushed valid", dout_valid, 0);
            chk("t6 flushed dout_i", $signed(dout_i), 0);
            chk("t6 flushed dout_q", $signed(dout_q), 0);
        end
        set_all(1000, 0);
        pulse();
        expect_out("t6 cleared weights", 0, 0, 0);
        for (int k = 0; k < CH; k++) wr_w(k, 16384, 0, 0);
        commit();
        pulse();
        expect_out("t6 restart", 32768000, 0, 0);

        // 7: gapped stream with mixed weights, checked by the model
        for (int k = 0; k < CH; k++) wr_w(k, 1000 * k + 7, 11 - 300 * k, 0);
        commit();
        pat = 7'b1001101;
        for (int n = 0; n < 7; n++) begin
            for (int k = 0; k < CH; k++)
                set_ch(k, 100 * n - 37 * k, 50 - 13 * n * k);
            din_valid = pat[n];
            @(negedge clk);
        end
        din_valid = 0;
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
